// File: rtl/uart_cmd_loader.sv
// Frame parser behind uart_rx: validates 11-byte command frames, issues word
// writes to the program memory and drives the core hold line.
module uart_cmd_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 270000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        frame_err,
    output logic [15:0] frames_ok
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

    state_t        state_r;
    logic [7:0]    cmd_r;
    logic [7:0]    chk_r;
    logic [1:0]    byte_idx_r;
    logic [TW-1:0] tmo_r;

    logic accept_s;
    logic in_frame_s;
    logic cmd_valid_s;
    logic tmo_expire_s;

    // Running frame checksum: XOR of every byte after SYNC.
    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign rx_data_ready = (state_r != ST_WRITE);
    assign accept_s      = rx_data_valid && rx_data_ready;
    assign tmo_expire_s  = in_frame_s && !accept_s && (tmo_r == TMO_LAST);

    // Decode which states are inside a frame (timeout armed) and which commands are legal.
    always_comb begin
        in_frame_s  = 1'b0;
        cmd_valid_s = 1'b0;
        case (state_r)
            ST_CMD, ST_ADDR, ST_DATA, ST_CHK: in_frame_s = 1'b1;
            default:                          in_frame_s = 1'b0;
        endcase
        case (cmd_r)
            8'h01, 8'h02, 8'h03: cmd_valid_s = 1'b1;
            default:             cmd_valid_s = 1'b0;
        endcase
    end

    // Frame sequencer with registered memory, hold and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_r      <= 8'h00;
            chk_r      <= 8'h00;
            byte_idx_r <= 2'd0;
            tmo_r      <= '0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            frame_err  <= 1'b0;
            frames_ok  <= 16'h0000;
        end else begin
            frame_err <= 1'b0;
            // An accepted byte always clears the gap counter, even on the expiry cycle.
            if (in_frame_s && !accept_s && !tmo_expire_s) begin
                tmo_r <= tmo_r + TMO_ONE;
            end else begin
                tmo_r <= '0;
            end

            if (tmo_expire_s) begin
                frame_err <= 1'b1;
                state_r   <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s && (rx_data == SYNC_BYTE)) begin
                            chk_r   <= 8'h00;
                            state_r <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (accept_s) begin
                            cmd_r      <= rx_data;
                            chk_r      <= chk_next(chk_r, rx_data);
                            byte_idx_r <= 2'd0;
                            state_r    <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (accept_s) begin
                            mem_addr[{byte_idx_r, 3'b000} +: 8] <= rx_data;
                            chk_r      <= chk_next(chk_r, rx_data);
                            byte_idx_r <= byte_idx_r + 2'd1;
                            if (byte_idx_r == 2'd3) begin
                                state_r <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept_s) begin
                            mem_wdata[{byte_idx_r, 3'b000} +: 8] <= rx_data;
                            chk_r      <= chk_next(chk_r, rx_data);
                            byte_idx_r <= byte_idx_r + 2'd1;
                            if (byte_idx_r == 2'd3) begin
                                state_r <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (accept_s) begin
                            if ((rx_data != chk_r) || !cmd_valid_s) begin
                                frame_err <= 1'b1;
                                state_r   <= ST_IDLE;
                            end else if (cmd_r == 8'h01) begin
                                mem_we  <= 1'b1;
                                state_r <= ST_WRITE;
                            end else begin
                                cpu_hold  <= (cmd_r == 8'h03);
                                frames_ok <= frames_ok + 16'd1;
                                state_r   <= ST_IDLE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (mem_ack) begin
                            mem_we    <= 1'b0;
                            frames_ok <= frames_ok + 16'd1;
                            state_r   <= ST_IDLE;
                        end
                    end
                    default: begin
                        mem_we  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Self-checking bench for uart_cmd_loader: scoreboard of expected memory
// writes plus per-scenario checks of hold line, error pulses and frame count.
module tb_uart_cmd_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        rx_data_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        cpu_hold;
    logic        frame_err;
    logic [15:0] frames_ok;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          err_seen = 0;
    int          exp_ok = 0;
    bit          ack_hold = 1'b0;
    logic [63:0] exp_q[$];

    uart_cmd_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .cpu_hold(cpu_hold), .frame_err(frame_err), .frames_ok(frames_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_seen <= err_seen + 1;
    end

    // Memory model: acknowledges each write and pops the scoreboard.
    initial begin
        logic [63:0] exp;
        forever begin
            @(posedge clk); #2;
            if (rst_n === 1'b1 && mem_we === 1'b1 && !ack_hold) begin
                cmp_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_write got addr=%h data=%h expected no write", mem_addr, mem_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== exp) begin
                        err_cnt++;
                        $display("FAIL write_data got %h expected %h", {mem_addr, mem_wdata}, exp);
                    end
                end
                mem_ack = 1'b1;
                @(posedge clk); #2;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_data_valid = 1'b1;
        while (rx_data_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL byte_accept got ready=%b expected 1 within 200 cycles", rx_data_ready);
        end else begin
            @(posedge clk); #1;
        end
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [7:0] chk_flip, input int gap);
        logic [7:0] fb [0:10];
        logic [7:0] chk;
        fb[0] = 8'hA5;
        fb[1] = cmd;
        for (int i = 0; i < 4; i++) begin
            fb[2 + i] = addr[8*i +: 8];
            fb[6 + i] = data[8*i +: 8];
        end
        chk = 8'h00;
        for (int i = 1; i < 10; i++) chk = chk ^ fb[i];
        fb[10] = chk ^ chk_flip;
        for (int i = 0; i < 11; i++) begin
            send_byte(fb[i]);
            if (i < 10) tick(gap);
        end
    endtask

    task automatic wait_write_done();
        int n;
        n = 0;
        while (mem_we === 1'b1 && n < 100) begin tick(1); n++; end
        cmp_cnt++;
        if (mem_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL write_complete got mem_we=%b expected 0 within 100 cycles", mem_we);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        cmp_cnt++;
        if ({rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold, frame_err, frames_ok} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 16'h0}) begin
            err_cnt++;
            $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h hold=%b err=%b ok=%0d expected 1 0 0 0 1 0 0",
                     rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold, frame_err, frames_ok);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write();
        exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF});
        send_frame(8'h01, 32'h0000_0100, 32'hDEAD_BEEF, 8'h00, 0);
        cmp_cnt++;
        if (mem_we !== 1'b1) begin
            err_cnt++;
            $display("FAIL write_latency got mem_we=%b expected 1", mem_we);
        end
        wait_write_done();
        exp_ok++;
        cmp_cnt++;
        if (frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL write_count got ok=%0d pending=%0d expected ok=%0d pending=0", frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_bad_chk();
        int e0;
        e0 = err_seen;
        send_frame(8'h01, 32'h0000_0100, 32'hDEAD_BEEF, 8'h01, 0);
        tick(3);
        cmp_cnt++;
        if (err_seen != e0 + 1 || mem_we !== 1'b0 || frames_ok !== 16'(exp_ok)) begin
            err_cnt++;
            $display("FAIL bad_chk got errs=%0d we=%b ok=%0d expected errs=%0d we=0 ok=%0d",
                     err_seen - e0, mem_we, frames_ok, 1, exp_ok);
        end
    endtask

    task automatic test_go_halt();
        send_frame(8'h02, 32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 0);
        exp_ok++;
        cmp_cnt++;
        if (cpu_hold !== 1'b0 || mem_we !== 1'b0 || frames_ok !== 16'(exp_ok)) begin
            err_cnt++;
            $display("FAIL go got hold=%b we=%b ok=%0d expected hold=0 we=0 ok=%0d", cpu_hold, mem_we, frames_ok, exp_ok);
        end
        send_frame(8'h03, 32'h0, 32'h0, 8'h00, 0);
        exp_ok++;
        cmp_cnt++;
        if (cpu_hold !== 1'b1 || frames_ok !== 16'(exp_ok)) begin
            err_cnt++;
            $display("FAIL halt got hold=%b ok=%0d expected hold=1 ok=%0d", cpu_hold, frames_ok, exp_ok);
        end
    endtask

    task automatic test_bad_cmd();
        int e0;
        e0 = err_seen;
        send_frame(8'h07, 32'h0000_0010, 32'h0000_0020, 8'h00, 0);
        tick(3);
        cmp_cnt++;
        if (err_seen != e0 + 1 || mem_we !== 1'b0 || frames_ok !== 16'(exp_ok)) begin
            err_cnt++;
            $display("FAIL bad_cmd got errs=%0d we=%b ok=%0d expected errs=1 we=0 ok=%0d", err_seen - e0, mem_we, frames_ok, exp_ok);
        end
    endtask

    task automatic test_garbage();
        int e0;
        e0 = err_seen;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        exp_q.push_back({32'h2000_0004, 32'hCAFE_F00D});
        send_frame(8'h01, 32'h2000_0004, 32'hCAFE_F00D, 8'h00, 0);
        wait_write_done();
        exp_ok++;
        cmp_cnt++;
        if (err_seen != e0 || frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL garbage got errs=%0d ok=%0d pending=%0d expected errs=0 ok=%0d pending=0",
                     err_seen - e0, frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h00);
        tick(TMO - 1);
        cmp_cnt++;
        if (err_seen != e0) begin
            err_cnt++;
            $display("FAIL timeout_early got errs=%0d expected 0", err_seen - e0);
        end
        tick(4);
        cmp_cnt++;
        if (err_seen != e0 + 1 || mem_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_fire got errs=%0d we=%b expected errs=1 we=0", err_seen - e0, mem_we);
        end
        // Maximum legal inter-byte gap: each byte lands on the expiry cycle and must win.
        exp_q.push_back({32'h0000_0200, 32'h0BAD_F00D});
        send_frame(8'h01, 32'h0000_0200, 32'h0BAD_F00D, 8'h00, TMO - 1);
        wait_write_done();
        exp_ok++;
        cmp_cnt++;
        if (err_seen != e0 + 1 || frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL timeout_recover got errs=%0d ok=%0d pending=%0d expected errs=1 ok=%0d pending=0",
                     err_seen - e0, frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({32'h0000_0300, 32'h1111_2222});
        exp_q.push_back({32'h0000_0304, 32'h3333_4444});
        send_frame(8'h01, 32'h0000_0300, 32'h1111_2222, 8'h00, 0);
        send_frame(8'h01, 32'h0000_0304, 32'h3333_4444, 8'h00, 0);
        wait_write_done();
        exp_ok += 2;
        cmp_cnt++;
        if (frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL back_to_back got ok=%0d pending=%0d expected ok=%0d pending=0", frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    task automatic test_hold_reset();
        int bad;
        send_frame(8'h02, 32'h0, 32'h0, 8'h00, 0);
        exp_ok++;
        ack_hold = 1'b1;
        exp_q.push_back({32'h0000_0040, 32'h55AA_55AA});
        send_frame(8'h01, 32'h0000_0040, 32'h55AA_55AA, 8'h00, 0);
        rx_data = 8'hA5;
        rx_data_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cmp_cnt++;
            if ({rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold} !== {1'b0, 1'b1, 32'h0000_0040, 32'h55AA_55AA, 1'b0}) begin
                err_cnt++;
                if (bad < 3)
                    $display("FAIL hold_stable got rdy=%b we=%b a=%h d=%h hold=%b expected 0 1 00000040 55aa55aa 0",
                             rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold);
                bad++;
            end
            tick(1);
        end
        rx_data_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold, frame_err, frames_ok} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 16'h0}) begin
            err_cnt++;
            $display("FAIL reset_mid_write got rdy=%b we=%b a=%h d=%h hold=%b err=%b ok=%0d expected 1 0 0 0 1 0 0",
                     rx_data_ready, mem_we, mem_addr, mem_wdata, cpu_hold, frame_err, frames_ok);
        end
        tick(2);
        rst_n = 1'b1;
        ack_hold = 1'b0;
        exp_q.delete();
        exp_ok = 0;
        tick(1);
        exp_q.push_back({32'h0000_0044, 32'h7777_8888});
        send_frame(8'h01, 32'h0000_0044, 32'h7777_8888, 8'h00, 0);
        wait_write_done();
        exp_ok++;
        cmp_cnt++;
        if (frames_ok !== 16'(exp_ok) || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL after_reset got ok=%0d pending=%0d expected ok=%0d pending=0", frames_ok, exp_q.size(), exp_ok);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_chk();
        test_go_halt();
        test_bad_cmd();
        test_garbage();
        test_timeout();
        test_back_to_back();
        test_hold_reset();
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
